// File: rtl/snn_config_loader_pkg.sv
// Shared definitions for the SNN configuration loader: command codes,
// FSM states, network dimensions and payload sizes.
package snn_config_loader_pkg;

  localparam logic [7:0] CMD_LOAD_W = 8'h01;
  localparam logic [7:0] CMD_LOAD_D = 8'h02;
  localparam logic [7:0] CMD_LOAD_P = 8'h03;
  localparam logic [7:0] CMD_COMMIT = 8'h04;
  localparam logic [7:0] CMD_ENABLE = 8'h05;

  localparam int L1_INPUTS    = 24;
  localparam int L1_NEURONS   = 8;
  localparam int L2_NEURONS   = 2;
  localparam int NUM_SYNAPSES = L1_INPUTS * L1_NEURONS + L1_NEURONS * L2_NEURONS;

  // Each delay field is a 3-bit delay plus an enable bit.
  localparam int DELAY_FIELD_W = 4;
  localparam int DELAY_BYTES   = NUM_SYNAPSES * DELAY_FIELD_W / 8;

  localparam int CNT_W = 7;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    LOAD_D,
    LOAD_P,
    LOAD_E,
    APPLY
  } state_t;

  function automatic int weight_bytes(input int nbits);
    return NUM_SYNAPSES * nbits / 8;
  endfunction

endpackage

// File: rtl/cfg_shadow_reg.sv
// Byte-addressed shadow register with a parallel active copy; the active
// copy takes the whole shadow image in one cycle when load is high.
module cfg_shadow_reg
  import snn_config_loader_pkg::*;
#(
  parameter int NBYTES = DELAY_BYTES
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [CNT_W-1:0]      wr_addr,
  input  logic [7:0]            wr_data,
  input  logic                  load,
  output logic [NBYTES*8-1:0]   active
);

  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_byte
      logic [7:0] shadow_reg;
      logic [7:0] active_reg;

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          shadow_reg <= '0;
          active_reg <= '0;
        end else begin
          if (wr_en && (wr_addr == CNT_W'(gi))) begin
            shadow_reg <= wr_data;
          end
          if (load) begin
            active_reg <= shadow_reg;
          end
        end
      end

      assign active[8*gi +: 8] = active_reg;
    end
  endgenerate

endmodule

// File: rtl/snn_config_loader.sv
// Byte-stream configuration loader for a two-layer SNN: commands fill shadow
// weights/delays/parameters, and COMMIT copies them to the active outputs.
module snn_config_loader
  import snn_config_loader_pkg::*;
#(
  parameter int NBITS = 2
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic [7:0]                            in_data,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic [NUM_SYNAPSES*NBITS-1:0]         weights,
  output logic [NUM_SYNAPSES*DELAY_FIELD_W-1:0] delays,
  output logic [NBITS-1:0]                      threshold,
  output logic [NBITS-1:0]                      decay,
  output logic [NBITS-1:0]                      refractory_period,
  output logic                                  net_enable,
  output logic                                  cfg_valid,
  output logic                                  busy,
  output logic                                  err_cmd
);

  localparam int              W_BYTES = weight_bytes(NBITS);
  localparam logic [CNT_W-1:0] W_LAST  = CNT_W'(W_BYTES - 1);
  localparam logic [CNT_W-1:0] D_LAST  = CNT_W'(DELAY_BYTES - 1);

  state_t             state_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               in_ready_reg;
  logic               busy_reg;
  logic               err_cmd_reg;
  logic               net_enable_reg;
  logic               cfg_valid_reg;
  logic [NBITS-1:0]   thr_shadow_reg;
  logic [NBITS-1:0]   decay_shadow_reg;
  logic [NBITS-1:0]   refr_shadow_reg;
  logic [NBITS-1:0]   threshold_reg;
  logic [NBITS-1:0]   decay_reg;
  logic [NBITS-1:0]   refr_reg;

  logic accept;
  logic apply;
  logic w_wr_en;
  logic d_wr_en;

  assign accept  = in_valid && in_ready_reg;
  assign apply   = (state_reg == APPLY);
  assign w_wr_en = accept && (state_reg == LOAD_W);
  assign d_wr_en = accept && (state_reg == LOAD_D);

  cfg_shadow_reg #(
    .NBYTES (W_BYTES)
  ) u_weights (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (w_wr_en),
    .wr_addr (count_reg),
    .wr_data (in_data),
    .load    (apply),
    .active  (weights)
  );

  cfg_shadow_reg #(
    .NBYTES (DELAY_BYTES)
  ) u_delays (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (d_wr_en),
    .wr_addr (count_reg),
    .wr_data (in_data),
    .load    (apply),
    .active  (delays)
  );

  // in_ready and busy are registered alongside each transition so they
  // reflect the state being entered on the same edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg        <= IDLE;
      count_reg        <= '0;
      in_ready_reg     <= 1'b0;
      busy_reg         <= 1'b0;
      err_cmd_reg      <= 1'b0;
      net_enable_reg   <= 1'b0;
      cfg_valid_reg    <= 1'b0;
      thr_shadow_reg   <= '0;
      decay_shadow_reg <= '0;
      refr_shadow_reg  <= '0;
      threshold_reg    <= '0;
      decay_reg        <= '0;
      refr_reg         <= '0;
    end else begin
      in_ready_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            count_reg <= '0;
            case (in_data)
              CMD_LOAD_W: begin state_reg <= LOAD_W; busy_reg <= 1'b1; end
              CMD_LOAD_D: begin state_reg <= LOAD_D; busy_reg <= 1'b1; end
              CMD_LOAD_P: begin state_reg <= LOAD_P; busy_reg <= 1'b1; end
              CMD_ENABLE: begin state_reg <= LOAD_E; busy_reg <= 1'b1; end
              CMD_COMMIT: begin state_reg <= APPLY;  in_ready_reg <= 1'b0; end
              default:    err_cmd_reg <= 1'b1;
            endcase
          end
        end
        LOAD_W, LOAD_D: begin
          if (accept) begin
            if (count_reg == ((state_reg == LOAD_W) ? W_LAST : D_LAST)) begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
              count_reg <= '0;
            end else begin
              count_reg <= count_reg + CNT_W'(1);
            end
          end
        end
        LOAD_P: begin
          if (accept) begin
            thr_shadow_reg   <= in_data[NBITS-1:0];
            decay_shadow_reg <= in_data[2*NBITS-1:NBITS];
            refr_shadow_reg  <= in_data[3*NBITS-1:2*NBITS];
            state_reg        <= IDLE;
            busy_reg         <= 1'b0;
          end
        end
        LOAD_E: begin
          if (accept) begin
            net_enable_reg <= in_data[0];
            state_reg      <= IDLE;
            busy_reg       <= 1'b0;
          end
        end
        APPLY: begin
          threshold_reg <= thr_shadow_reg;
          decay_reg     <= decay_shadow_reg;
          refr_reg      <= refr_shadow_reg;
          cfg_valid_reg <= 1'b1;
          state_reg     <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready          = in_ready_reg;
  assign busy              = busy_reg;
  assign err_cmd           = err_cmd_reg;
  assign net_enable        = net_enable_reg;
  assign cfg_valid         = cfg_valid_reg;
  assign threshold         = threshold_reg;
  assign decay             = decay_reg;
  assign refractory_period = refr_reg;

endmodule

// File: doc/snn_config_loader.md
SNN_CONFIG_LOADER -- requirements
Module: snn_config_loader

Interface
REQ-001 Parameter NBITS, default 2, synaptic weight/threshold/decay/refractory precision; legal values 1..2.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 in_data  input  8  configuration byte stream.
REQ-005 in_valid  input  1  in_data valid this cycle.
REQ-006 in_ready  output  1  loader accepts in_data this cycle; byte transfers when in_valid and in_ready are both high.
REQ-007 weights  output  208*NBITS  active packed weights; layer-1 (24x8) in the low 192*NBITS bits, layer-2 (8x2) above them.
REQ-008 delays  output  832  active packed delays; 208 fields of 4 bits, with bits [2:0] the delay value and bit 3 the delay-enable.
REQ-009 threshold, decay, refractory_period  output  NBITS each  active neuron parameters.
REQ-010 net_enable  output  1  network enable.
REQ-011 cfg_valid  output  1  at least one COMMIT has completed since reset.
REQ-012 busy  output  1  a command payload is in progress.
REQ-013 err_cmd  output  1  sticky flag for an unknown command byte.

Function
REQ-014 The block SHALL hold separate shadow and active copies of weights, delays and parameters; the outputs always show the active copy.
REQ-015 FSM states SHALL be IDLE, LOAD_W, LOAD_D, LOAD_P, LOAD_E and APPLY.
REQ-016 In IDLE, an accepted byte is a command: 0x01 goes to LOAD_W, 0x02 to LOAD_D, 0x03 to LOAD_P, 0x04 to APPLY, 0x05 to LOAD_E; any other value sets err_cmd and stays in IDLE.
REQ-017 LOAD_W SHALL accept exactly 26*NBITS payload bytes; payload byte k writes shadow weights bits [8k+7:8k]; the FSM returns to IDLE after the last byte.
REQ-018 LOAD_D SHALL accept exactly 104 payload bytes, with byte k writing shadow delays bits [8k+7:8k]; the FSM returns to IDLE after the last byte.
REQ-019 LOAD_P SHALL accept one byte and load shadow fields: threshold = byte[NBITS-1:0], decay = byte[2*NBITS-1:NBITS], refractory_period = byte[3*NBITS-1:2*NBITS]; remaining bits are ignored.
REQ-020 LOAD_E SHALL accept one byte, write byte[0] directly to net_enable with no shadowing, and return to IDLE.
REQ-021 APPLY SHALL last exactly one cycle; in it, all active copies load from shadow simultaneously and cfg_valid is set; the FSM then goes to IDLE.
REQ-022 Active outputs SHALL change on the clock edge that ends APPLY, i.e. one cycle after the COMMIT byte is accepted.
REQ-023 in_ready SHALL be 1 in every state except APPLY and reset; no byte is lost or duplicated.
REQ-024 busy SHALL be 1 in LOAD_W, LOAD_D, LOAD_P and LOAD_E.
REQ-025 The payload byte counter SHALL be 7 bits, clear on each new command, and never wrap within a payload.
REQ-026 A byte equal to a command code inside a payload SHALL be treated as data.
REQ-027 A partial load followed by COMMIT cannot occur (COMMIT is only decoded in IDLE); shadow bytes already written stay written.
REQ-028 A COMMIT with no prior load SHALL copy the shadow values (reset values) to active and still set cfg_valid.
REQ-029 in_valid low SHALL stall the FSM and counter with no timeout.

Reset
REQ-030 While reset_n=0 at a clock edge: FSM goes to IDLE, counter to 0, all shadow and active registers to 0, net_enable=0, cfg_valid=0, err_cmd=0, in_ready=0.
REQ-031 Reset mid-payload SHALL abandon the load; the first byte after reset is decoded as a command.
REQ-032 in_ready SHALL rise on the first cycle after reset_n returns high.

Structure
REQ-033 A shared package SHALL hold the command codes, the state enumeration, the counts WEIGHT_BYTES(NBITS)=26*NBITS and DELAY_BYTES=104, and the layer dimensions 24/8/2.
REQ-034 One sub-module, cfg_shadow_reg, SHALL implement the byte-addressed shadow register with a parallel active copy and a load strobe, instantiated for weights and for delays.

Verification
REQ-035 Reset, then stream 0x03, 0x39, 0x04 with NBITS=2 -> threshold=1, decay=2, refractory_period=3 exactly one cycle after 0x04 is accepted; cfg_valid=1.
REQ-036 Stream 0x01 plus 52 bytes of 0xA5 with no commit -> weights stays 0; after 0x04, weights = all 0xA5 pattern.
REQ-037 Stream 0x02 plus 104 bytes k=0..103 with in_valid toggling randomly, then 0x04 -> delays byte k = k; in_ready low only in the APPLY cycle.
REQ-038 Send 0x7F -> err_cmd=1 and stays set through valid commands; it clears only on reset_n=0.
REQ-039 Assert reset_n=0 for one cycle after 0x02 plus 50 bytes, then send 0x05, 0x01 -> net_enable=1, delays=0, busy=0.
